// File: rtl/drf_io_pkg.sv
// Shared register map and sizing helpers
// for the DRF memory-mapped I/O ports.
package drf_io_pkg;

  localparam int REG_SEL_W = 2;

  localparam logic [REG_SEL_W-1:0] REG_IN     = 2'd0;
  localparam logic [REG_SEL_W-1:0] REG_OUT    = 2'd1;
  localparam logic [REG_SEL_W-1:0] REG_STATUS = 2'd2;
  localparam logic [REG_SEL_W-1:0] REG_MASK   = 2'd3;

  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Per-channel input path: synchroniser chain,
// debounce filter and change detect.
module io_debounce
  import drf_io_pkg::*;
#(
  parameter int PORT_W          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PORT_W-1:0] i_pin,
  output logic [PORT_W-1:0] o_deb,
  output logic [PORT_W-1:0] o_edge
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  // In bypass the debounced register is the last sync stage.
  localparam int CHAIN = (DEBOUNCE_CYCLES == 0) ?
                         SYNC_STAGES - 1 : SYNC_STAGES;

  logic [PORT_W-1:0] r_sync [CHAIN];
  logic [PORT_W-1:0] r_deb;
  logic [PORT_W-1:0] w_sync;
  logic [PORT_W-1:0] w_flip;

  assign w_sync = r_sync[CHAIN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHAIN; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_pin;
      for (int i = 1; i < CHAIN; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign w_flip = w_sync ^ r_deb;
  end else begin : g_filter
    localparam logic [CNT_W-1:0] LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt [PORT_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int b = 0; b < PORT_W; b++) r_cnt[b] <= '0;
      end else begin
        for (int b = 0; b < PORT_W; b++) begin
          if (w_sync[b] == r_deb[b] || r_cnt[b] == LAST)
            r_cnt[b] <= '0;
          else
            r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end

    always_comb begin
      w_flip = '0;
      for (int b = 0; b < PORT_W; b++)
        w_flip[b] = (w_sync[b] != r_deb[b]) &&
                    (r_cnt[b] == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_deb <= '0;
    else        r_deb <= r_deb ^ w_flip;
  end

  assign o_deb  = r_deb;
  assign o_edge = w_flip;

endmodule

// File: rtl/io_port_controller.sv
// Multi-channel memory-mapped I/O port block:
// register file, address decode, read mux, irq.
module io_port_controller
  import drf_io_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int PORT_W          = 4,
  parameter int DATA_W          = 8,
  parameter int ADDR_W          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_read_en,
  input  logic                       in_write_en,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_data_valid,
  input  logic [CHANNELS*PORT_W-1:0] in_port,
  output logic [CHANNELS*PORT_W-1:0] out_port,
  output logic                       out_irq
);

  localparam int CH_W = ADDR_W - REG_SEL_W;

  logic [CH_W-1:0]      w_ch;
  logic [REG_SEL_W-1:0] w_reg;
  logic [CHANNELS-1:0]  w_hit;

  logic [CHANNELS-1:0][PORT_W-1:0] w_deb;
  logic [CHANNELS-1:0][PORT_W-1:0] w_edge;
  logic [CHANNELS-1:0][PORT_W-1:0] w_clr;
  logic [CHANNELS-1:0][PORT_W-1:0] r_out;
  logic [CHANNELS-1:0][PORT_W-1:0] r_status;
  logic [CHANNELS-1:0][PORT_W-1:0] r_mask;

  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_irq;
  logic              w_unused_data;

  assign w_ch  = in_addr[ADDR_W-1:REG_SEL_W];
  assign w_reg = in_addr[REG_SEL_W-1:0];
  assign w_unused_data = ^in_data;

  // Channel indices past CHANNELS never hit.
  always_comb begin
    w_hit = '0;
    for (int c = 0; c < CHANNELS; c++)
      w_hit[c] = (w_ch == CH_W'(c));
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    io_debounce #(
      .PORT_W         (PORT_W),
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_pin (in_port[c*PORT_W +: PORT_W]),
      .o_deb (w_deb[c]),
      .o_edge(w_edge[c])
    );
  end

  always_comb begin
    w_clr = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (in_write_en && w_hit[c] && w_reg == REG_STATUS)
        w_clr[c] = in_data[PORT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_status <= '0;
      r_mask   <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_write_en && w_hit[c] && w_reg == REG_OUT)
          r_out[c] <= in_data[PORT_W-1:0];
        if (in_write_en && w_hit[c] && w_reg == REG_MASK)
          r_mask[c] <= in_data[PORT_W-1:0];
        // A fresh edge beats a same-cycle clear.
        r_status[c] <= (r_status[c] & ~w_clr[c]) | w_edge[c];
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_hit[c]) begin
        case (w_reg)
          REG_IN:     w_rd = DATA_W'(w_deb[c]);
          REG_OUT:    w_rd = DATA_W'(r_out[c]);
          REG_STATUS: w_rd = DATA_W'(r_status[c]);
          default:    w_rd = DATA_W'(r_mask[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_valid <= in_read_en;
      if (in_read_en) r_data <= w_rd;
      r_irq <= |(r_status & r_mask);
    end
  end

  assign out_data       = r_data;
  assign out_data_valid = r_valid;
  assign out_port       = r_out;
  assign out_irq        = r_irq;

endmodule

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
- Parametrised successor to the single fixed 4-bit in/out port of the DRF system.
- Provides CHANNELS independent memory-mapped I/O ports on the 8-bit data bus.
- Each channel has:
  - a configurable synchroniser;
  - a configurable debounce filter;
  - sticky edge-capture status;
  - a maskable interrupt line.
- Sits beside the data memory manager, decoded on a local address window; the control unit reads and writes it like data memory.

Parameters:
- CHANNELS, 2, number of independent ports
- PORT_W, 4, bits per port (1..DATA_W)
- DATA_W, 8, data bus width
- ADDR_W, 4, local address width (must be >= clog2(CHANNELS)+2)
- SYNC_STAGES, 2, input synchroniser flops (>=2)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles before a debounced input changes (0 = bypass)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_read_en  in  1  read strobe
- in_write_en  in  1  write strobe
- in_addr  in  ADDR_W  local register address
- in_data  in  DATA_W  write data
- out_data  out  DATA_W  read data, registered
- out_data_valid  out  1  read data valid pulse
- in_port  in  CHANNELS*PORT_W  raw asynchronous pins; channel c is bits [c*PORT_W +: PORT_W]
- out_port  out  CHANNELS*PORT_W  output latches
- out_irq  out  1  OR of all (status & mask)

Behaviour:
- Reset:
  - Clock is clk; reset is asynchronous, active-low (rst_n).
  - While rst_n=0: out_port=0, out_data=0, out_data_valid=0, out_irq=0.
  - All synchroniser flops, debounced values, counters, status and mask registers are 0.
  - Reset asserted mid-operation aborts any pending read and clears all captured edges.
- Address map: in_addr = {channel index, reg[1:0]}. Registers:
  - 0 IN: read-only, debounced input value.
  - 1 OUT: read/write, output latch.
  - 2 STATUS: write-1-to-clear; sticky, bit i set on any change of debounced bit i.
  - 3 MASK: read/write, interrupt enable per bit.
- Width rule: register data occupies bits [PORT_W-1:0]; upper bits read 0 and are ignored on write.
- Out-of-range channel index: read returns 0 with a valid pulse; write is ignored.
- Read latency: in_read_en at cycle N gives out_data and out_data_valid=1 at edge N+1. out_data_valid is a one-cycle pulse; out_data holds its last value otherwise.
- Write: takes effect at the edge of the cycle in which in_write_en=1. A write to OUT is visible on out_port from the next cycle.
- Read and write in the same cycle to the same register: the read returns the pre-write value.
- Input path per bit:
  - SYNC_STAGES flop chain, then the debounce filter.
  - Debounce: a counter resets whenever the synchronised bit equals the debounced bit. When it differs for DEBOUNCE_CYCLES consecutive cycles, the debounced bit takes the new value and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES is never propagated.
  - Total latency from pin to IN: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Status priority: an edge detected in the same cycle as a W1C of that bit leaves the bit set (set wins).
- out_irq is registered, updated one cycle after a status or mask change, and is deasserted only when all (status & mask) bits are 0.
- Counter saturation: the debounce counter never wraps; it is sized clog2(DEBOUNCE_CYCLES+1).

Decomposition:
- Package drf_io_pkg:
  - register offsets REG_IN=0, REG_OUT=1, REG_STATUS=2, REG_MASK=3;
  - REG_SEL_W=2;
  - a function computing the counter width.
- Sub-module io_debounce holds the per-channel synchroniser, debounce filter and edge detect (PORT_W wide). It is instantiated CHANNELS times by a generate loop; the top level holds the register file, address decode, read mux and irq reduction.

Test Plan:
- Reset: drive in_port=8'hFF with rst_n=0 -> out_port=0, out_irq=0; after release, IN ch0 reads 4'hF only after SYNC_STAGES+DEBOUNCE_CYCLES=6 cycles, and STATUS ch0 reads 4'hF.
- Write then read: write 8'hA5 to addr 1 (ch0 OUT) -> out_port[3:0]=4'h5 next cycle; read addr 1 -> out_data=8'h05 one cycle later with a single-cycle out_data_valid.
- Debounce: a 3-cycle pulse on in_port[4] -> IN ch1 stays 0 and STATUS ch1 stays 0; a 10-cycle pulse -> IN ch1 bit0=1 and STATUS ch1=4'h1.
- Interrupt: write MASK ch1=4'h1 and generate an edge on ch1 bit0 -> out_irq=1; write 8'h01 to addr 6 -> out_irq=0 two cycles later.
- W1C race: align a new debounced edge on ch0 bit2 with a write of 8'h04 to addr 2 -> STATUS ch0 bit2 remains 1.
- Out-of-range: with CHANNELS=2 and ADDR_W=4, read addr 9 -> out_data=0 with valid=1; write addr 9 -> no register changes.
